command_word_decoder: RTL

- Write-side counterpart of the 8259A data bus buffer. Accepts CPU writes (write, address, data_bus_in) and sequences ICW1→ICW2→[ICW3]→[ICW4].
- Decodes post-init writes into OCW1/OCW2/OCW3.
- Holds the registered configuration, mask and read-select state consumed by the bus buffer, priority resolver and cascade logic.

---
 rtl/pic8259_pkg.sv | 37 +++
 rtl/rising_edge_detect.sv | 21 ++
 rtl/command_word_decoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pic8259_pkg.sv
// rtl/pic8259_pkg.sv - 8259A command word state encoding and field bit positions
package pic8259_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    // ICW1 (A0=0, D4=1)
    localparam int ICW1_SEL  = 4;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_IC4  = 0;

    // ICW4
    localparam int ICW4_SFNM = 4;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_AEOI = 1;

    // OCW2
    localparam int OCW2_R    = 7;
    localparam int OCW2_SL   = 6;
    localparam int OCW2_EOI  = 5;

    // OCW3 (D3 separates OCW3 from OCW2)
    localparam int OCW3_SEL  = 3;
    localparam int OCW3_ESMM = 6;
    localparam int OCW3_SMM  = 5;
    localparam int OCW3_P    = 2;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - level to single-cycle pulse on each 0->1 transition
module rising_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic signal_i,
    output logic pulse_o
);

    logic signal_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            signal_q <= 1'b0;
        end else begin
            signal_q <= signal_i;
        end
    end

    assign pulse_o = signal_i & ~signal_q;

endmodule

// File: rtl/command_word_decoder.sv
// rtl/command_word_decoder.sv - 8259A ICW sequencer and OCW decoder
// Holds the configuration, mask and read-select state for the rest of the PIC.
module command_word_decoder
    import pic8259_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       write,
    input  logic       read,
    input  logic       address,
    input  logic [7:0] data_bus_in,
    output logic       initialized,
    output logic       level_or_edge_triggered,
    output logic       single_or_cascade,
    output logic [4:0] interrupt_vector_address,
    output logic [7:0] cascade_device_config,
    output logic       auto_eoi,
    output logic       buffered_mode,
    output logic       buffered_master_or_slave,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       eoi_strobe,
    output logic       specific_eoi,
    output logic       set_priority_strobe,
    output logic       rotate_strobe,
    output logic [2:0] ocw2_level,
    output logic       auto_rotate_mode,
    output logic       special_mask_mode,
    output logic       enable_read_register,
    output logic       read_register_isr_or_irr
);

    logic write_edge;
    logic read_edge;

    rising_edge_detect u_write_edge (
        .clock    (clock),
        .reset    (reset),
        .signal_i (write),
        .pulse_o  (write_edge)
    );

    rising_edge_detect u_read_edge (
        .clock    (clock),
        .reset    (reset),
        .signal_i (read),
        .pulse_o  (read_edge)
    );

    state_t state_q, state_d;

    logic       ltim_q, ltim_d;
    logic       sngl_q, sngl_d;
    logic       ic4_q, ic4_d;
    logic [4:0] vector_q, vector_d;
    logic [7:0] cascade_q, cascade_d;
    logic       aeoi_q, aeoi_d;
    logic       buf_q, buf_d;
    logic       ms_q, ms_d;
    logic       sfnm_q, sfnm_d;
    logic [7:0] mask_q, mask_d;
    logic       eoi_q, eoi_d;
    logic       specific_q, specific_d;
    logic       set_prio_q, set_prio_d;
    logic       rotate_q, rotate_d;
    logic [2:0] level_q, level_d;
    logic       arot_q, arot_d;
    logic       smm_q, smm_d;
    logic       err_q, err_d;
    logic       ris_q, ris_d;
    logic       poll_q, poll_d;

    logic is_icw1;
    logic icw_data;
    logic ocw_cmd;
    logic is_ocw2;
    logic is_ocw3;
    logic poll_close;

    assign is_icw1    = write_edge & ~address & data_bus_in[ICW1_SEL];
    assign icw_data   = write_edge & address;
    assign ocw_cmd    = write_edge & ~address & ~data_bus_in[ICW1_SEL] & (state_q == ST_READY);
    assign is_ocw2    = ocw_cmd & ~data_bus_in[OCW3_SEL];
    assign is_ocw3    = ocw_cmd & data_bus_in[OCW3_SEL];
    // A write in the same cycle always wins over the read edge.
    assign poll_close = read_edge & ~address & poll_q & ~write_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_UNINIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_icw1) begin
            state_d = ST_WAIT_ICW2;
        end else if (icw_data) begin
            case (state_q)
                ST_WAIT_ICW2: begin
                    if (!sngl_q)    state_d = ST_WAIT_ICW3;
                    else if (ic4_q) state_d = ST_WAIT_ICW4;
                    else            state_d = ST_READY;
                end
                ST_WAIT_ICW3: state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: state_d = ST_READY;
                default:      state_d = state_q;
            endcase
        end
    end

    always_comb begin
        initialized = (state_q == ST_READY);
    end

    always_comb begin
        ltim_d     = ltim_q;
        sngl_d     = sngl_q;
        ic4_d      = ic4_q;
        vector_d   = vector_q;
        cascade_d  = cascade_q;
        aeoi_d     = aeoi_q;
        buf_d      = buf_q;
        ms_d       = ms_q;
        sfnm_d     = sfnm_q;
        mask_d     = mask_q;
        eoi_d      = 1'b0;
        specific_d = 1'b0;
        set_prio_d = 1'b0;
        rotate_d   = 1'b0;
        level_d    = level_q;
        arot_d     = arot_q;
        smm_d      = smm_q;
        err_d      = err_q;
        ris_d      = ris_q;
        poll_d     = poll_q;

        if (is_icw1) begin
            ltim_d = data_bus_in[ICW1_LTIM];
            sngl_d = data_bus_in[ICW1_SNGL];
            ic4_d  = data_bus_in[ICW1_IC4];
            mask_d = 8'h00;
            smm_d  = 1'b0;
            arot_d = 1'b0;
            poll_d = 1'b0;
            aeoi_d = 1'b0;
            buf_d  = 1'b0;
            ms_d   = 1'b0;
            sfnm_d = 1'b0;
            err_d  = 1'b1;
            ris_d  = 1'b0;
        end else if (icw_data) begin
            case (state_q)
                ST_WAIT_ICW2: vector_d = data_bus_in[7:3];
                ST_WAIT_ICW3: cascade_d = data_bus_in;
                ST_WAIT_ICW4: begin
                    sfnm_d = data_bus_in[ICW4_SFNM];
                    buf_d  = data_bus_in[ICW4_BUF];
                    ms_d   = data_bus_in[ICW4_MS];
                    aeoi_d = data_bus_in[ICW4_AEOI];
                end
                ST_READY:     mask_d = data_bus_in;
                default:      mask_d = mask_q;
            endcase
        end else if (is_ocw2) begin
            level_d = data_bus_in[2:0];
            if (data_bus_in[OCW2_EOI]) begin
                eoi_d      = 1'b1;
                specific_d = data_bus_in[OCW2_SL];
                rotate_d   = data_bus_in[OCW2_R];
            end else if (data_bus_in[OCW2_R] && data_bus_in[OCW2_SL]) begin
                set_prio_d = 1'b1;
            end else if (data_bus_in[OCW2_R]) begin
                arot_d = 1'b1;
            end else if (!data_bus_in[OCW2_SL]) begin
                arot_d = 1'b0;
            end
        end else if (is_ocw3) begin
            if (data_bus_in[OCW3_ESMM]) smm_d = data_bus_in[OCW3_SMM];
            if (data_bus_in[OCW3_RR])   ris_d = data_bus_in[OCW3_RIS];
            if (data_bus_in[OCW3_P]) begin
                poll_d = 1'b1;
                err_d  = 1'b0;
            end
        end else if (poll_close) begin
            poll_d = 1'b0;
            err_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            vector_q   <= 5'd0;
            cascade_q  <= 8'h00;
            aeoi_q     <= 1'b0;
            buf_q      <= 1'b0;
            ms_q       <= 1'b0;
            sfnm_q     <= 1'b0;
            mask_q     <= 8'h00;
            eoi_q      <= 1'b0;
            specific_q <= 1'b0;
            set_prio_q <= 1'b0;
            rotate_q   <= 1'b0;
            level_q    <= 3'd0;
            arot_q     <= 1'b0;
            smm_q      <= 1'b0;
            err_q      <= 1'b1;
            ris_q      <= 1'b0;
            poll_q     <= 1'b0;
        end else begin
            ltim_q     <= ltim_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            vector_q   <= vector_d;
            cascade_q  <= cascade_d;
            aeoi_q     <= aeoi_d;
            buf_q      <= buf_d;
            ms_q       <= ms_d;
            sfnm_q     <= sfnm_d;
            mask_q     <= mask_d;
            eoi_q      <= eoi_d;
            specific_q <= specific_d;
            set_prio_q <= set_prio_d;
            rotate_q   <= rotate_d;
            level_q    <= level_d;
            arot_q     <= arot_d;
            smm_q      <= smm_d;
            err_q      <= err_d;
            ris_q      <= ris_d;
            poll_q     <= poll_d;
        end
    end

    assign level_or_edge_triggered  = ltim_q;
    assign single_or_cascade        = sngl_q;
    assign interrupt_vector_address = vector_q;
    assign cascade_device_config    = cascade_q;
    assign auto_eoi                 = aeoi_q;
    assign buffered_mode            = buf_q;
    assign buffered_master_or_slave = ms_q;
    assign special_fully_nested     = sfnm_q;
    assign interrupt_mask           = mask_q;
    assign eoi_strobe               = eoi_q;
    assign specific_eoi             = specific_q;
    assign set_priority_strobe      = set_prio_q;
    assign rotate_strobe            = rotate_q;
    assign ocw2_level               = level_q;
    assign auto_rotate_mode         = arot_q;
    assign special_mask_mode        = smm_q;
    assign enable_read_register     = err_q;
    assign read_register_isr_or_irr = ris_q;

endmodule
